// File: rtl/lutram_pkg.sv
// Shared definitions for the muxed-write-port LUT RAM: source-select codes,
// controller state encoding and the per-bit source mux function.
package lutram_pkg;

    // Per-bit source select codes; 2'b11 is reserved.
    localparam logic [1:0] MUX_SIG = 2'b00;
    localparam logic [1:0] MUX_VLO = 2'b01;
    localparam logic [1:0] MUX_VHI = 2'b10;
    localparam logic [1:0] MUX_RSV = 2'b11;

    // Controller states: post-reset clear sweep, then normal operation.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Select one bit from its pin or a constant. The reserved code behaves
    // as VLO unless xon asks for an X so misuse shows up in simulation.
    function automatic logic mux_bit(input logic [1:0] code, input logic pin, input logic xon);
        logic res;
        case (code)
            MUX_SIG: res = pin;
            MUX_VLO: res = 1'b0;
            MUX_VHI: res = 1'b1;
            default: res = xon ? 1'bx : 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lutram_bitmux.sv
// Combinational per-bit source mux for one vector (write data or write address).
// Each bit takes its pin, constant 0 or constant 1 according to a 2-bit code in MUX.
module lutram_bitmux
    import lutram_pkg::*;
#(
    parameter int           N   = 4,
    parameter logic [2*N-1:0] MUX = '0,
    parameter logic         XON = 1'b0
) (
    input  logic [N-1:0] pin,
    output logic [N-1:0] eff
);

    // Apply the per-bit code to every bit of the vector.
    always_comb begin
        eff = '0;
        for (int i = 0; i < N; i++) begin
            eff[i] = mux_bit(MUX[2*i +: 2], pin[i], XON);
        end
    end

endmodule

// File: rtl/lutram_wport.sv
// Distributed RAM with a muxed, posted write port.
//
// Handshake: WE and RE are sampled on every rising CLK edge while BUSY is low;
// there is no ready back-pressure. While BUSY is high (clear sweep) WE is
// dropped and flagged on WERR for one cycle, and RE is dropped with RVALID=0.
// RVALID qualifies RDO: one cycle after RE when RD_REG=1, same cycle when 0.
//
// Writes are posted: the muxed address/data captured at edge N are written
// into the array at edge N+1. With BYPASS=1 a read of the posted address
// returns the posted data, so a read one edge after a write sees it.
module lutram_wport
    import lutram_pkg::*;
#(
    parameter int              DW      = 4,
    parameter int              AW      = 4,
    parameter logic [2*DW-1:0] WD_MUX  = '0,
    parameter logic [2*AW-1:0] WAD_MUX = '0,
    parameter int              RD_REG  = 1,
    parameter int              BYPASS  = 1,
    parameter int              CLR_EN  = 1,
    parameter logic [DW-1:0]   CLR_VAL = '0,
    parameter logic            XON     = 1'b0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          WE,
    input  logic [AW-1:0] WAD,
    input  logic [DW-1:0] WD,
    input  logic          RE,
    input  logic [AW-1:0] RAD,
    output logic [DW-1:0] RDO,
    output logic          RVALID,
    output logic          BUSY,
    output logic          WERR,
    output logic          dbg_state
);

    localparam int DEPTH = 1 << AW;

    state_t          state;
    logic [AW-1:0]   clr_cnt;
    logic            busy;

    logic [AW-1:0]   eff_wad;
    logic [DW-1:0]   eff_wd;

    logic            pend_vld;
    logic [AW-1:0]   pend_addr;
    logic [DW-1:0]   pend_data;

    logic [DW-1:0]   mem [DEPTH];
    logic [DW-1:0]   rd_sel;
    logic            werr_q;

    assign busy      = (state == ST_CLEAR);
    assign BUSY      = busy;
    assign WERR      = werr_q;
    assign dbg_state = state;

    // Source muxes sit ahead of all storage.
    lutram_bitmux #(.N(DW), .MUX(WD_MUX), .XON(XON)) u_wd_mux (
        .pin (WD),
        .eff (eff_wd)
    );

    lutram_bitmux #(.N(AW), .MUX(WAD_MUX), .XON(XON)) u_wad_mux (
        .pin (WAD),
        .eff (eff_wad)
    );

    // Controller: clear sweep over every address after reset, then run until the next reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= (CLR_EN != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == {AW{1'b1}}) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Posted write register: captures an accepted write, drains on the next edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
        end else begin
            pend_vld <= WE & ~busy;
            if (WE && !busy) begin
                pend_addr <= eff_wad;
                pend_data <= eff_wd;
            end
        end
    end

    // Array write: sweep value during CLEAR, otherwise commit the posted write.
    // A reset edge writes nothing, so a pending write is discarded.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (busy) begin
                mem[clr_cnt] <= CLR_VAL;
            end else if (pend_vld) begin
                mem[pend_addr] <= pend_data;
            end
        end
    end

    // Read selection: posted data wins over the array when bypass is enabled and addresses match.
    always_comb begin
        rd_sel = mem[RAD];
        if ((BYPASS != 0) && pend_vld && (pend_addr == RAD)) begin
            rd_sel = pend_data;
        end
    end

    // Write-while-busy error pulse, one cycle after the rejected WE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            werr_q <= 1'b0;
        end else begin
            werr_q <= WE & busy;
        end
    end

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [DW-1:0] rdo_q;
            logic          rvalid_q;

            // Registered read: RDO updates only on an accepted RE, otherwise holds.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    rdo_q    <= '0;
                    rvalid_q <= 1'b0;
                end else if (RE && !busy) begin
                    rdo_q    <= rd_sel;
                    rvalid_q <= 1'b1;
                end else begin
                    rvalid_q <= 1'b0;
                end
            end

            assign RDO    = rdo_q;
            assign RVALID = rvalid_q;
        end else begin : g_rd_comb
            assign RDO    = rd_sel;
            assign RVALID = RE & ~busy;
        end
    endgenerate

endmodule

// File: tb/tb_lutram_wport.sv
// Bench for lutram_wport: four instances covering the default configuration,
// bypass disabled, constant write-port mux bits, and combinational read with
// no clear sweep. Expected values come from simple array models of the RAM.
module tb_lutram_wport;

    logic       clk;
    logic       rst [4];
    logic       we  [4];
    logic       re  [4];
    logic [3:0] wad [4];
    logic [3:0] wd  [4];
    logic [3:0] rad [4];
    wire  [3:0] rdo    [4];
    wire        rvalid [4];
    wire        busy   [4];
    wire        werr   [4];
    wire        dbg    [4];

    int total;
    int bad;

    // Models: contents visible to a read issued at the current edge.
    logic [3:0] ref0 [16];
    logic [3:0] ref1 [16];
    logic [3:0] ref2 [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    lutram_wport u_dflt (
        .CLK(clk), .RST(rst[0]), .WE(we[0]), .WAD(wad[0]), .WD(wd[0]), .RE(re[0]), .RAD(rad[0]),
        .RDO(rdo[0]), .RVALID(rvalid[0]), .BUSY(busy[0]), .WERR(werr[0]), .dbg_state(dbg[0])
    );

    lutram_wport #(.BYPASS(0)) u_nobyp (
        .CLK(clk), .RST(rst[1]), .WE(we[1]), .WAD(wad[1]), .WD(wd[1]), .RE(re[1]), .RAD(rad[1]),
        .RDO(rdo[1]), .RVALID(rvalid[1]), .BUSY(busy[1]), .WERR(werr[1]), .dbg_state(dbg[1])
    );

    lutram_wport #(.WD_MUX(8'b10_01_00_00), .WAD_MUX(8'b00_00_00_10)) u_mux (
        .CLK(clk), .RST(rst[2]), .WE(we[2]), .WAD(wad[2]), .WD(wd[2]), .RE(re[2]), .RAD(rad[2]),
        .RDO(rdo[2]), .RVALID(rvalid[2]), .BUSY(busy[2]), .WERR(werr[2]), .dbg_state(dbg[2])
    );

    lutram_wport #(.RD_REG(0), .CLR_EN(0), .XON(1'b1), .WD_MUX(8'b00_00_00_11)) u_comb (
        .CLK(clk), .RST(rst[3]), .WE(we[3]), .WAD(wad[3]), .WD(wd[3]), .RE(re[3]), .RAD(rad[3]),
        .RDO(rdo[3]), .RVALID(rvalid[3]), .BUSY(busy[3]), .WERR(werr[3]), .dbg_state(dbg[3])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        we[k]  = 1'b0;
        re[k]  = 1'b0;
        wad[k] = 4'h0;
        wd[k]  = 4'h0;
        rad[k] = 4'h0;
    endtask

    task automatic reset_inst(input int k);
        idle(k);
        rst[k] = 1'b1;
        tick();
        rst[k] = 1'b0;
    endtask

    // Reset state, exact sweep length, WERR timing, RE ignored while busy, then all-clear read-out.
    task automatic test_reset();
        logic exp_busy;
        logic exp_werr;
        reset_inst(0);
        if (rdo[0] !== 4'h0) begin bad++; $display("FAIL reset_rdo: got %h expected 0", rdo[0]); end
        total++;
        for (int c = 1; c <= 20; c++) begin
            exp_busy = (c <= 16);
            exp_werr = (c == 4);
            total++;
            if (busy[0] !== exp_busy) begin
                bad++; $display("FAIL reset_busy c=%0d: got %b expected %b", c, busy[0], exp_busy);
            end
            total++;
            if (werr[0] !== exp_werr) begin
                bad++; $display("FAIL reset_werr c=%0d: got %b expected %b", c, werr[0], exp_werr);
            end
            total++;
            if (rvalid[0] !== 1'b0) begin
                bad++; $display("FAIL reset_rvalid c=%0d: got %b expected 0", c, rvalid[0]);
            end
            we[0]  = (c == 3);
            wad[0] = 4'h6;
            wd[0]  = 4'h5;
            re[0]  = (c == 5);
            rad[0] = 4'h1;
            tick();
        end
        idle(0);
        for (int a = 0; a < 16; a++) ref0[a] = 4'h0;
        for (int a = 0; a <= 16; a++) begin
            if (a > 0) begin
                total++;
                if (rvalid[0] !== 1'b1 || rdo[0] !== ref0[a-1]) begin
                    bad++; $display("FAIL clear_read a=%0d: got v=%b d=%h expected v=1 d=%h", a-1, rvalid[0], rdo[0], ref0[a-1]);
                end
            end
            re[0]  = (a < 16);
            rad[0] = 4'(a);
            tick();
        end
        total++;
        if (rvalid[0] !== 1'b0) begin bad++; $display("FAIL clear_read_end: got %b expected 0", rvalid[0]); end
    endtask

    // Write 0xA to 5, read 5 on the same edge and the next edges, with and without bypass.
    task automatic test_bypass();
        for (int k = 0; k < 2; k++) begin
            we[k] = 1'b1; wad[k] = 4'h5; wd[k] = 4'hA;
            re[k] = 1'b1; rad[k] = 4'h5;
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (rdo[k] !== 4'h0 || rvalid[k] !== 1'b1) begin
                bad++; $display("FAIL same_edge_old k=%0d: got v=%b d=%h expected v=1 d=0", k, rvalid[k], rdo[k]);
            end
            we[k] = 1'b0;
        end
        tick();
        total++;
        if (rdo[0] !== 4'hA) begin bad++; $display("FAIL bypass_on: got %h expected a", rdo[0]); end
        total++;
        if (rdo[1] !== 4'h0) begin bad++; $display("FAIL bypass_off: got %h expected 0", rdo[1]); end
        tick();
        total++;
        if (rdo[1] !== 4'hA) begin bad++; $display("FAIL bypass_off_n2: got %h expected a", rdo[1]); end
        idle(0);
        idle(1);
        tick();
        ref0[5] = 4'hA;
        ref1[5] = 4'hA;
    endtask

    // Full-rate writes to every address, then full-rate reads.
    task automatic test_back_to_back();
        for (int a = 0; a < 16; a++) begin
            we[0] = 1'b1; wad[0] = 4'(a); wd[0] = 4'(a) ^ 4'hF;
            ref0[a] = 4'(a) ^ 4'hF;
            tick();
        end
        idle(0);
        for (int a = 0; a <= 16; a++) begin
            if (a > 0) begin
                total++;
                if (rvalid[0] !== 1'b1 || rdo[0] !== ref0[a-1]) begin
                    bad++; $display("FAIL b2b_read a=%0d: got v=%b d=%h expected v=1 d=%h", a-1, rvalid[0], rdo[0], ref0[a-1]);
                end
            end
            re[0]  = (a < 16);
            rad[0] = 4'(a);
            tick();
        end
        total++;
        if (rvalid[0] !== 1'b0) begin bad++; $display("FAIL b2b_end: got %b expected 0", rvalid[0]); end
    endtask

    // Random traffic on a few addresses, driving the bypass and non-bypass instances identically.
    task automatic test_random();
        logic       r_we, r_re, lag_we;
        logic [3:0] r_wad, r_wd, r_rad, lag_wad, lag_wd;
        logic [3:0] exp0, exp1, hold0, hold1;
        lag_we = 1'b0; lag_wad = 4'h0; lag_wd = 4'h0;
        hold0 = 4'h0; hold1 = 4'h0;
        for (int i = 0; i < 200; i++) begin
            r_we  = 1'($urandom_range(0, 1));
            r_re  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            r_wad = 4'($urandom_range(0, 3));
            r_wd  = 4'($urandom_range(0, 15));
            r_rad = 4'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                we[k] = r_we; wad[k] = r_wad; wd[k] = r_wd; re[k] = r_re; rad[k] = r_rad;
            end
            // Bypass: a read sees every earlier write. No bypass: writes need one extra edge.
            exp0 = ref0[r_rad];
            exp1 = ref1[r_rad];
            if (r_we) ref0[r_wad] = r_wd;
            if (lag_we) ref1[lag_wad] = lag_wd;
            lag_we = r_we; lag_wad = r_wad; lag_wd = r_wd;
            tick();
            if (r_re) begin
                hold0 = exp0;
                hold1 = exp1;
            end
            total++;
            if (rvalid[0] !== r_re || rdo[0] !== hold0) begin
                bad++; $display("FAIL rand_byp i=%0d: got v=%b d=%h expected v=%b d=%h", i, rvalid[0], rdo[0], r_re, hold0);
            end
            total++;
            if (rvalid[1] !== r_re || rdo[1] !== hold1) begin
                bad++; $display("FAIL rand_nobyp i=%0d: got v=%b d=%h expected v=%b d=%h", i, rvalid[1], rdo[1], r_re, hold1);
            end
        end
        idle(0);
        idle(1);
        tick();
        if (lag_we) ref1[lag_wad] = lag_wd;
    endtask

    function automatic logic [3:0] mux_wd_ref(input logic [3:0] d);
        return (d & 4'b0011) | 4'b1000;
    endfunction

    function automatic logic [3:0] mux_wad_ref(input logic [3:0] a);
        return a | 4'b0001;
    endfunction

    // Constant data bits and a constant address bit that aliases writes onto odd addresses.
    task automatic test_mux();
        for (int a = 0; a < 16; a++) ref2[a] = 4'h0;
        we[2] = 1'b1; wad[2] = 4'h4; wd[2] = 4'h7;
        tick();
        we[2] = 1'b0; re[2] = 1'b1; rad[2] = 4'h5;
        tick();
        total++;
        if (rdo[2] !== 4'hB) begin bad++; $display("FAIL mux_data: got %h expected b", rdo[2]); end
        rad[2] = 4'h4;
        tick();
        total++;
        if (rdo[2] !== 4'h0) begin bad++; $display("FAIL mux_alias: got %h expected 0", rdo[2]); end
        re[2] = 1'b0;
        ref2[5] = 4'hB;
        for (int i = 0; i < 12; i++) begin
            we[2]  = 1'b1;
            wad[2] = 4'($urandom_range(0, 15));
            wd[2]  = 4'($urandom_range(0, 15));
            ref2[mux_wad_ref(wad[2])] = mux_wd_ref(wd[2]);
            tick();
        end
        idle(2);
        for (int a = 0; a <= 16; a++) begin
            if (a > 0) begin
                total++;
                if (rvalid[2] !== 1'b1 || rdo[2] !== ref2[a-1]) begin
                    bad++; $display("FAIL mux_read a=%0d: got v=%b d=%h expected v=1 d=%h", a-1, rvalid[2], rdo[2], ref2[a-1]);
                end
            end
            re[2]  = (a < 16);
            rad[2] = 4'(a);
            tick();
        end
        idle(2);
    endtask

    // Reset one edge after a write: the posted write is dropped and a full sweep follows.
    task automatic test_rst_mid();
        logic exp_busy;
        we[0] = 1'b1; wad[0] = 4'h2; wd[0] = 4'h9;
        tick();
        we[0] = 1'b0;
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            exp_busy = (c <= 16);
            total++;
            if (busy[0] !== exp_busy) begin
                bad++; $display("FAIL rst_mid_busy c=%0d: got %b expected %b", c, busy[0], exp_busy);
            end
            tick();
        end
        for (int a = 0; a < 16; a++) ref0[a] = 4'h0;
        re[0] = 1'b1; rad[0] = 4'h2;
        tick();
        total++;
        if (rvalid[0] !== 1'b1 || rdo[0] !== ref0[2]) begin
            bad++; $display("FAIL rst_mid_data: got v=%b d=%h expected v=1 d=%h", rvalid[0], rdo[0], ref0[2]);
        end
        idle(0);
        tick();
    endtask

    // Combinational read, no sweep, reserved code on data bit 0.
    task automatic test_comb();
        logic [2:0] hi;
        reset_inst(3);
        total++;
        if (busy[3] !== 1'b0) begin bad++; $display("FAIL comb_busy: got %b expected 0", busy[3]); end
        we[3] = 1'b1; wad[3] = 4'h3; wd[3] = 4'h6;
        tick();
        we[3] = 1'b0; re[3] = 1'b1; rad[3] = 4'h3;
        #1;
        hi = rdo[3][3:1];
        total++;
        if (rvalid[3] !== 1'b1 || hi !== 3'b011) begin
            bad++; $display("FAIL comb_pending: got v=%b d[3:1]=%b expected v=1 d[3:1]=011", rvalid[3], hi);
        end
        tick();
        we[3] = 1'b1; wad[3] = 4'h7; wd[3] = 4'hE; re[3] = 1'b0;
        tick();
        we[3] = 1'b0;
        tick();
        re[3] = 1'b1; rad[3] = 4'h3;
        #1;
        hi = rdo[3][3:1];
        total++;
        if (hi !== 3'b011) begin bad++; $display("FAIL comb_rad3: got %b expected 011", hi); end
        rad[3] = 4'h7;
        #1;
        hi = rdo[3][3:1];
        total++;
        if (hi !== 3'b111) begin bad++; $display("FAIL comb_rad7: got %b expected 111", hi); end
        re[3] = 1'b0;
        #1;
        total++;
        if (rvalid[3] !== 1'b0) begin bad++; $display("FAIL comb_rvalid: got %b expected 0", rvalid[3]); end
        idle(3);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int k = 0; k < 4; k++) begin
            idle(k);
            rst[k] = 1'b1;
        end
        for (int a = 0; a < 16; a++) begin
            ref0[a] = 4'h0;
            ref1[a] = 4'h0;
            ref2[a] = 4'h0;
        end
        tick();
        for (int k = 0; k < 4; k++) rst[k] = 1'b0;
        test_reset();
        test_bypass();
        test_back_to_back();
        test_random();
        test_mux();
        test_rst_mid();
        test_comb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
